xt_hb_lsu: RTL
==============

XT_HB_LSU -- requirements
Module: xt_hb_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: bus cycles to wait for a finish strobe before a bus error; legal range 2..255.
REQ-002 SHALL have port hb_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the core presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_misalign, output, 1 bit: the request was misaligned and issued no bus access.
REQ-013 SHALL have port rsp_bus_err, output, 1 bit: the finish strobe timed out.
REQ-014 SHALL have ports hb_raddr and hb_waddr, outputs, 32 bits each: bus read and write addresses.
REQ-015 SHALL have port hb_wdata, output, 32 bits: bus write data, right-aligned.
REQ-016 SHALL have port hb_write_width, output, 2 bits: 0 = byte, 1 = half, 2 = word.
REQ-017 SHALL have ports hb_ren and hb_wen, outputs, 1 bit each: one-cycle bus strobes.
REQ-018 SHALL have port hb_rdata, input, 32 bits: slave read data, requested bytes right-aligned at bit 0.
REQ-019 SHALL have ports hb_read_finish and hb_write_finish, inputs, 1 bit each: slave completion flags.

Function
REQ-020 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 SHALL accept a request at the edge where req_valid=1 in IDLE, and SHALL register address, data, width and type at that edge.
REQ-022 SHALL treat LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, as misaligned: no strobe; next state RESP with rsp_misalign=1.
REQ-023 SHALL treat funct3 011/110/111 (and store funct3 1xx) as misaligned-class illegal with the same response.
REQ-024 SHALL, for an aligned load accepted at edge T: drive hb_ren=1 for exactly the cycle after T; enter RD_WAIT; hold hb_raddr stable until the response.
REQ-025 SHALL, for an aligned store: drive hb_wen=1 for the one cycle after acceptance, with hb_waddr, hb_wdata and hb_write_width valid in that cycle and held until the response; enter WR_WAIT.
REQ-026 SHALL sample the finish flag only from the second cycle after acceptance onward (the cycle after the strobe); a finish already high during the strobe cycle SHALL be ignored.
REQ-027 SHALL, on a sampled finish, capture the result and enter RESP; rsp_valid SHALL be 1 for exactly the one RESP cycle, then the FSM returns to IDLE.
REQ-028 SHALL give a minimum load/store latency, acceptance edge to rsp_valid, of 3 cycles, for a slave whose finish arrives one cycle after the strobe.
REQ-029 SHALL extend loads as follows: LB sign-extends hb_rdata[7:0]; LBU zero-extends it; LH sign-extends hb_rdata[15:0]; LHU zero-extends it; LW passes all 32 bits.
REQ-030 SHALL count wait cycles in an 8-bit counter cleared at acceptance.
REQ-031 SHALL, when the counter reaches TIMEOUT_CYCLES without a finish, enter RESP with rsp_bus_err=1 and rsp_rdata=0.
REQ-032 SHALL give finish priority over timeout when both occur in the same cycle.
REQ-033 SHALL hold hb_ren and hb_wen at 0 in every cycle other than their single strobe cycle; ren and wen SHALL never both be 1.
REQ-034 SHALL keep rsp_misalign, rsp_bus_err and rsp_rdata valid only while rsp_valid=1, and SHALL drive them to 0 otherwise.

Reset
REQ-035 SHALL, while rst_n=0, force the FSM to IDLE, the counter to 0, and all outputs to 0 except req_ready. req_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-036 SHALL, on reset mid-transaction, abandon the transaction with no rsp_valid and no further strobes; a slave finish arriving afterwards SHALL be ignored in IDLE.

Verification
REQ-037 SHALL pass: LB addr 0x0000_0103, hb_rdata=0x0000_0080 with read finish one cycle after hb_ren -> hb_ren single pulse, rsp_rdata=0xFFFF_FF80, rsp_valid 3 cycles after acceptance.
REQ-038 SHALL pass: SH addr 0x0000_0202, wdata 0x1234_ABCD -> hb_wen single pulse, hb_write_width=1, hb_waddr=0x202, hb_wdata=0x1234_ABCD; hb_write_finish tied 1 -> rsp_valid, rsp_rdata=0.
REQ-039 SHALL pass: LW addr 0x0000_0006 -> no hb_ren, rsp_misalign=1 one cycle after acceptance.
REQ-040 SHALL pass: load with finish tied 0, TIMEOUT_CYCLES=16 -> rsp_bus_err=1 and rsp_rdata=0, then req_ready returns to 1.
REQ-041 SHALL pass: rst_n pulsed low in RD_WAIT, then finish=1 -> no rsp_valid, FSM in IDLE, req_ready=1.
REQ-042 SHALL pass: back-to-back LHU 0x10 (hb_rdata 0x0000_8001) then LBU 0x11 (hb_rdata 0x0000_00FF) -> responses 0x0000_8001 then 0x0000_00FF, in order.

Source files
------------

// File: rtl/xt_hb_lsu_if.sv
// Core-request / halfword-bus interface bundle for the xt_hb_lsu load/store unit.
// Ports: req_* and rsp_* (core side); hb_* (bus side).
// Modports: master = the LSU, which masters the bus and serves the core;
//           slave  = the environment, i.e. the core plus the bus slave.
interface xt_hb_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_bus_err;
    logic [31:0] hb_raddr;
    logic [31:0] hb_waddr;
    logic [31:0] hb_wdata;
    logic [1:0]  hb_write_width;
    logic        hb_ren;
    logic        hb_wen;
    logic [31:0] hb_rdata;
    logic        hb_read_finish;
    logic        hb_write_finish;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_bus_err,
        output hb_raddr, hb_waddr, hb_wdata, hb_write_width, hb_ren, hb_wen,
        input  hb_rdata, hb_read_finish, hb_write_finish
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_bus_err,
        input  hb_raddr, hb_waddr, hb_wdata, hb_write_width, hb_ren, hb_wen,
        output hb_rdata, hb_read_finish, hb_write_finish
    );
endinterface

// File: rtl/xt_hb_lsu.sv
// RV32I load/store unit: one outstanding request, single-cycle bus strobe, finish or timeout.
// Latency: misaligned -> response in the cycle after acceptance; bus access -> 3rd cycle minimum.
// Backpressure: req_ready only in IDLE; the bus has no backpressure beyond the finish/timeout wait.
// Ports: hb_clk, rst_n (async active-low), bus (xt_hb_lsu_if.master: req_*, rsp_*, hb_*).
module xt_hb_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         hb_clk,
    input  logic         rst_n,
    xt_hb_lsu_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    // Wait counter is 0 in the strobe cycle, so the last permitted wait cycle is TIMEOUT_CYCLES-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;
    // Held low through reset so req_ready rises only at the first edge after release.
    logic        rdy_q;

    logic        accept;
    logic        bad_req;
    logic        fin;
    logic [31:0] ld_ext;

    assign accept = bus.req_valid && rdy_q && (state_q == IDLE);
    assign fin    = we_q ? bus.hb_write_finish : bus.hb_read_finish;

    // Illegal width codes and misaligned halfword/word accesses share one response.
    always_comb begin
        bad_req = 1'b0;
        if (bus.req_we) begin
            if (bus.req_funct3[2] || bus.req_funct3 == 3'b011) bad_req = 1'b1;
        end else begin
            if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                bus.req_funct3 == 3'b111) bad_req = 1'b1;
        end
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) bad_req = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) bad_req = 1'b1;
    end

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{bus.hb_rdata[7]}}, bus.hb_rdata[7:0]};
            3'b001:  ld_ext = {{16{bus.hb_rdata[15]}}, bus.hb_rdata[15:0]};
            3'b100:  ld_ext = {24'd0, bus.hb_rdata[7:0]};
            3'b101:  ld_ext = {16'd0, bus.hb_rdata[15:0]};
            default: ld_ext = bus.hb_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 8'd0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
                    if (bad_req) begin
                        mis_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        strobe_d = 1'b1;
                        state_d  = bus.req_we ? WR_WAIT : RD_WAIT;
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A finish seen in the strobe cycle is stale from an earlier access.
                if (!strobe_q && fin) begin
                    state_d = RESP;
                    rdata_d = we_q ? 32'd0 : ld_ext;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = 32'd0;
                mis_d   = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            strobe_q <= 1'b0;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'd0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
            rdy_q    <= 1'b1;
        end
    end

    assign bus.req_ready      = rdy_q && (state_q == IDLE);
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_rdata      = (state_q == RESP) ? rdata_q : 32'd0;
    assign bus.rsp_misalign   = (state_q == RESP) && mis_q;
    assign bus.rsp_bus_err    = (state_q == RESP) && err_q;
    assign bus.hb_raddr       = addr_q;
    assign bus.hb_waddr       = addr_q;
    assign bus.hb_wdata       = wdata_q;
    assign bus.hb_write_width = f3_q[1:0];
    assign bus.hb_ren         = strobe_q && (state_q == RD_WAIT);
    assign bus.hb_wen         = strobe_q && (state_q == WR_WAIT);
endmodule
